// File: rtl/cic_decim_ctrl_if.sv
// Rate-configuration handshake and qualified sample output between the
// CIC decimator controller and its user.
interface cic_decim_ctrl_if #(
  parameter int DW     = 20,
  parameter int RATE_W = 3
);
  logic [RATE_W-1:0] cfg_rate;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DW-1:0]     dout;
  logic              dout_valid;

  modport master (output cfg_rate, cfg_valid, input cfg_ready, dout, dout_valid);
  modport slave  (input cfg_rate, cfg_valid, output cfg_ready, dout, dout_valid);
endinterface

// File: rtl/cic_decim_ctrl.sv
// Sequencer for the 8-stage CIC decimator: reset/flush on every rate change,
// discard settling outputs, then forward qualified samples.
module cic_decim_ctrl #(
  parameter int DW          = 20,
  parameter int RATE_W      = 3,
  parameter int FLUSH_CYC   = 2,
  parameter int SETTLE_OUTS = 9
) (
  input  logic              clk,
  input  logic              reset,
  cic_decim_ctrl_if.slave   bus,
  input  logic              cken_in,
  output logic              cic_reset,
  output logic [RATE_W-1:0] cic_decimrate,
  output logic              cic_cken_in,
  input  logic              cic_cken_out,
  input  logic [DW-1:0]     cic_dout,
  output logic              locked
);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam int SW = $clog2(SETTLE_OUTS + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;

  state_t          state, state_nx;
  logic [FW-1:0]   flush_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            gate, cfg_ready, cken_d1, dout_valid;
  logic [DW-1:0]   dout;
  logic            cic_reset_nx, cfg_ready_nx, gate_nx, locked_nx;
  logic            xfer, ev, flush_done, settle_done;

  assign bus.cfg_ready  = cfg_ready;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign cic_cken_in    = cken_in & gate;

  // cic_cken_out is a level; only the cycle after a forwarded strobe carries news.
  assign xfer        = bus.cfg_valid & cfg_ready;
  assign ev          = cic_cken_out & cken_d1;
  assign flush_done  = (flush_cnt == FW'(FLUSH_CYC - 1));
  assign settle_done = ev && (settle_cnt == SW'(SETTLE_OUTS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cic_reset <= 1'b1;
      cfg_ready <= 1'b1;
      gate      <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nx;
      cic_reset <= cic_reset_nx;
      cfg_ready <= cfg_ready_nx;
      gate      <= gate_nx;
      locked    <= locked_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (xfer)        state_nx = FLUSH;
      FLUSH:   if (flush_done)  state_nx = SETTLE;
      SETTLE:  if (settle_done) state_nx = RUN;
      RUN:     if (xfer)        state_nx = FLUSH;
      default:                  state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge.
  always_comb begin
    cic_reset_nx = (state_nx == IDLE)   || (state_nx == FLUSH);
    cfg_ready_nx = (state_nx == IDLE)   || (state_nx == RUN);
    gate_nx      = (state_nx == SETTLE) || (state_nx == RUN);
    locked_nx    = (state_nx == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cic_decimrate <= '0;
      flush_cnt     <= '0;
      settle_cnt    <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      cken_d1       <= 1'b0;
    end else begin
      cken_d1    <= cic_cken_in;
      dout_valid <= 1'b0;
      if (xfer) begin
        // A new rate beats a coincident sample: the sample is dropped.
        cic_decimrate <= bus.cfg_rate;
        flush_cnt     <= '0;
        settle_cnt    <= '0;
      end else begin
        unique case (state)
          FLUSH:   if (!flush_done) flush_cnt <= flush_cnt + 1'b1;
          SETTLE:  if (ev && !settle_done) settle_cnt <= settle_cnt + 1'b1;
          RUN: begin
            if (ev) begin
              dout       <= cic_dout;
              dout_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Bench for cic_decim_ctrl: countdown-style behavioural model, a toy CIC
// that decimates forwarded strobes, directed scenarios then random traffic.
module tb_cic_decim_ctrl;
  localparam int DW = 20, RATE_W = 3, FLUSH_CYC = 2, SETTLE_OUTS = 9;

  logic              clk = 1'b0, reset = 1'b1, cken_in = 1'b0, cic_cken_out = 1'b0;
  logic [DW-1:0]     cic_dout = '0;
  logic              cic_reset, cic_cken_in, locked;
  logic [RATE_W-1:0] cic_decimrate;

  cic_decim_ctrl_if #(.DW(DW), .RATE_W(RATE_W)) bus ();

  cic_decim_ctrl #(.DW(DW), .RATE_W(RATE_W), .FLUSH_CYC(FLUSH_CYC), .SETTLE_OUTS(SETTLE_OUTS)) dut (
    .clk(clk), .reset(reset), .bus(bus), .cken_in(cken_in), .cic_reset(cic_reset),
    .cic_decimrate(cic_decimrate), .cic_cken_in(cic_cken_in), .cic_cken_out(cic_cken_out),
    .cic_dout(cic_dout), .locked(locked)
  );

  always #5 clk = ~clk;

  // Behavioural model: sequence expressed as remaining flush clocks / settle events.
  bit                m_started = 0, m_idle = 1, m_run = 0, m_dv = 0, m_ckd1 = 0;
  int                m_flush = 0, m_settle = 0;
  logic [RATE_W-1:0] m_rate = '0;
  logic [DW-1:0]     m_dout = '0;

  function automatic bit m_gate();
    return (m_flush == 0 && m_settle > 0) || m_run;
  endfunction

  always @(posedge clk) begin : model
    bit ev, xf, g;
    if (reset) begin
      m_started = 1; m_idle = 1; m_run = 0; m_flush = 0; m_settle = 0;
      m_rate = '0; m_dout = '0; m_dv = 0; m_ckd1 = 0;
    end else begin
      g  = m_gate();
      ev = cic_cken_out && m_ckd1;
      xf = bus.cfg_valid && (m_idle || m_run);
      m_ckd1 = cken_in && g;
      m_dv = 0;
      if (xf) begin
        m_rate = bus.cfg_rate; m_idle = 0; m_run = 0;
        m_flush = FLUSH_CYC; m_settle = SETTLE_OUTS;
      end else if (m_flush > 0) begin
        m_flush--;
      end else if (m_settle > 0) begin
        if (ev) begin
          m_settle--;
          if (m_settle == 0) m_run = 1;
        end
      end else if (m_run && ev) begin
        m_dout = cic_dout; m_dv = 1;
      end
    end
  end

  int n_cmp = 0, n_bad = 0, cyc = 0, ph = 0, fcnt = 0, mode = 0;
  int n_dv = 0, n_g = 0, n_ru = 0;
  bit ru_en = 0, g_prev = 0, r_prev = 0;
  bit o_rst, o_rdy, o_lock, o_dv;
  logic [RATE_W-1:0] o_rate;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: compare at negedge, then after the edge update the toy CIC.
  task automatic tick();
    logic [DW+RATE_W+4:0] a, e;
    @(negedge clk);
    cyc++;
    o_rst = cic_reset; o_rdy = bus.cfg_ready; o_lock = locked; o_dv = bus.dout_valid;
    o_rate = cic_decimrate;
    g_prev = cic_cken_in; r_prev = cic_reset;
    if (bus.dout_valid) n_dv++;
    if (cic_cken_in && !locked) n_g++;
    if (ru_en && bus.cfg_ready && !locked) n_ru++;
    if (m_started) begin
      a = {cic_reset, bus.cfg_ready, locked, bus.dout_valid, cic_cken_in, cic_decimrate, bus.dout};
      e = {m_idle || m_flush > 0, m_idle || m_run, m_run, m_dv, cken_in && m_gate(), m_rate, m_dout};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got rst=%b rdy=%b lock=%b dv=%b ck=%b rate=%0d dout=%h, expected rst=%b rdy=%b lock=%b dv=%b ck=%b rate=%0d dout=%h",
                 cyc, a[DW+RATE_W+4], a[DW+RATE_W+3], a[DW+RATE_W+2], a[DW+RATE_W+1], a[DW+RATE_W],
                 a[DW+RATE_W-1:DW], a[DW-1:0], e[DW+RATE_W+4], e[DW+RATE_W+3], e[DW+RATE_W+2],
                 e[DW+RATE_W+1], e[DW+RATE_W], e[DW+RATE_W-1:DW], e[DW-1:0]);
      end
    end
    @(posedge clk);
    #1;
    if (r_prev) begin
      fcnt = 0; cic_cken_out = 1'b0;
    end else if (g_prev) begin
      fcnt++;
      cic_cken_out = (fcnt % (int'(cic_decimrate) + 1)) == 0;
    end
    if (mode == 1) cic_cken_out = 1'b1;
    if (mode == 2 && $urandom_range(0, 3) == 0) cic_cken_out = ~cic_cken_out;
    cic_dout = DW'($urandom);
  endtask

  task automatic strobe_ticks(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      cken_in = (ph % per) == 0; ph++;
      tick();
    end
  endtask

  task automatic wait_lock(input int per, input int budget);
    int i = 0;
    do begin
      cken_in = (ph % per) == 0; ph++;
      tick(); i++;
    end while (!o_lock && i < budget);
    chk("lock_reached", o_lock, 1);
  endtask

  task automatic xfer(input int rate);
    bus.cfg_rate = RATE_W'(rate); bus.cfg_valid = 1'b1; cken_in = 1'b0;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int cnt, found, hold;
    bus.cfg_valid = 1'b0; bus.cfg_rate = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle: no config for 100 clocks.
    n_dv = 0; n_g = 0;
    strobe_ticks(100, 4);
    chk("idle_dout_valid_count", n_dv, 0);
    chk("idle_gated_strobes", n_g, 0);
    chk("idle_cic_reset", o_rst, 1);
    chk("idle_cfg_ready", o_rdy, 1);

    // Rate 3, strobe every 4 clocks.
    n_g = 0;
    xfer(3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cken_in = (ph % 4) == 0; ph++;
      tick();
      if (o_rst) cnt++; else break;
    end
    chk("flush_clocks", cnt, FLUSH_CYC);
    wait_lock(4, 400);
    chk("settle_strobes_rate3", n_g, 36);
    n_dv = 0;
    strobe_ticks(256, 4);
    chk("run_dout_valid_per_256clk", n_dv, 16);

    // Rate change 3 -> 7 while running.
    n_g = 0; n_dv = 0; n_ru = 0; ru_en = 1;
    xfer(7);
    strobe_ticks(1, 4);
    chk("lock_drop", o_lock, 0);
    chk("ready_drop", o_rdy, 0);
    wait_lock(4, 1000);
    ru_en = 0;
    chk("ready_while_unlocked", n_ru, 0);
    chk("reconfig_dout_valid", n_dv, 0);
    chk("settle_strobes_rate7", n_g, 72);
    chk("new_rate", o_rate, 7);

    // Config request coincident with an output event.
    found = 0;
    for (int i = 0; i < 200; i++) begin
      strobe_ticks(1, 4);
      if (cic_cken_out && g_prev) begin found = 1; break; end
    end
    chk("event_found", found, 1);
    xfer(3);
    tick();
    chk("collide_dout_valid", o_dv, 0);
    chk("collide_cic_reset", o_rst, 1);
    wait_lock(4, 400);

    // cic_cken_out stuck high without strobes.
    cken_in = 1'b0;
    repeat (3) tick();
    mode = 1; n_dv = 0;
    repeat (10) tick();
    mode = 0;
    chk("stuck_out_dout_valid", n_dv, 0);
    chk("stuck_out_still_locked", o_lock, 1);

    // Same rate again, reset after 5 settle events.
    n_g = 0;
    xfer(3);
    tick();
    chk("same_rate_flush", o_rst, 1);
    cnt = 0;
    while (n_g < 21 && cnt < 400) begin strobe_ticks(1, 4); cnt++; end
    chk("five_events_reached", n_g >= 21, 1);
    reset = 1'b1; cken_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_cic_reset", o_rst, 1);
    chk("rst_cfg_ready", o_rdy, 1);
    chk("rst_locked", o_lock, 0);
    chk("rst_rate", o_rate, 0);
    n_g = 0;
    xfer(3);
    wait_lock(4, 400);
    chk("fresh_settle_strobes", n_g, 36);

    // Random traffic against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      cken_in = $urandom_range(0, 2) == 0;
      if (hold == 0) begin
        bus.cfg_valid = $urandom_range(0, 29) == 0;
        bus.cfg_rate  = RATE_W'($urandom);
        hold = $urandom_range(0, 60);
      end else hold--;
      mode  = ($urandom_range(0, 9) == 0) ? 2 : 0;
      reset = $urandom_range(0, 499) == 0;
      tick();
    end
    reset = 1'b0; bus.cfg_valid = 1'b0; mode = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
